invsqrt_arbiter: RTL
====================

// Module: invsqrt_arbiter
// PURPOSE
//  Shares one invsqrt core among N_REQ requesters with round-robin arbitration.
//  Each requester posts a 32-bit IEEE-754 single operand and gets 1/sqrt(x) back.
//  The block sequences the core's start/ready handshake and holds the operand stable.
//  It routes each result to the requester that owns it.
//  Sits between the pipeline clients and the single invsqrt instance.
// PARAMETERS
//  N_REQ           4    number of requesters (2..8)
//  GW              $clog2(N_REQ)  grant index width (derived, do not override)
//  TIMEOUT_CYCLES  64   watchdog limit in WAIT; used only with INVSQRT_ARB_TIMEOUT_EN
// PORTS
//  clk            in   1         single clock, rising edge
//  rst_n          in   1         synchronous reset, active-low
//  req_valid      in   N_REQ     requester i has an operand pending (held until ack)
//  req_data       in   32*N_REQ  operand of requester i at bits [32*i+31:32*i]
//  req_ack        out  N_REQ     one-hot, 1-cycle pulse: operand of requester i taken
//  resp_valid     out  N_REQ     one-hot, 1-cycle pulse: result for requester i
//  resp_data      out  32        result, valid only while resp_valid != 0
//  resp_err       out  1         result is a timeout substitute (qualifies resp_valid)
//  busy           out  1         1 while an operation is in flight (state WAIT)
//  core_start     out  1         start to invsqrt core, 1-cycle pulse
//  core_float_in  out  32        operand to core, held stable from start until ready
//  core_float_out in   32        core result
//  core_ready     in   1         core done; level, completion = rising edge
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (rst_n=0 at a clk edge): state=IDLE, rr_ptr=0, and all outputs = 0,
//    including core_float_in, resp_data and the ready_q edge register.
//  - Reset mid-operation abandons the op; no resp_valid is issued for it.
//  - IDLE, any req_valid=1:
//    - Pick the first set bit searching rr_ptr, rr_ptr+1, ... mod N_REQ; call it g.
//    - Next edge: core_float_in<=req_data[g], req_ack[g]<=1, core_start<=1,
//      grant<=g, rr_ptr<=(g+1) mod N_REQ, state<=WAIT.
//  - IDLE, no request: state and outputs hold; pulse outputs are 0.
//  - WAIT:
//    - req_ack and core_start return to 0 after one cycle.
//    - Requesters must drop or refresh req_valid in the ack cycle.
//    - No new grant is made while in WAIT; req_valid is ignored.
//    - Completion = core_ready & ~ready_q, where ready_q is core_ready delayed 1 cycle.
//      A ready level left high from the previous op is not a completion.
//    - On completion, next edge: resp_data<=core_float_out, resp_valid[grant]<=1,
//      resp_err<=0, state<=IDLE.
//  - Back-to-back: a new grant may be issued in the cycle after resp_valid. That is
//    also the earliest IDLE cycle.
//  - Latency, request seen in IDLE at cycle T:
//    - ack/start at T+1.
//    - Response at (core ready edge cycle)+1.
//  - Fairness: a continuously requesting client waits at most N_REQ-1 operations.
//  - Operand and result are passed through bit-exact; no arithmetic in this block.
// CONFIGURATION
//  - INVSQRT_ARB_TIMEOUT_EN defined:
//    - A wait counter clears on core_start and increments each WAIT cycle.
//    - If it reaches TIMEOUT_CYCLES with no completion: resp_valid[grant]=1,
//      resp_data=32'h7FC00000 (qNaN), resp_err=1, state<=IDLE.
//    - A completion on the same cycle as the timeout wins: normal response, err=0.
//  - INVSQRT_ARB_TIMEOUT_EN undefined: no counter; WAIT lasts until completion;
//    resp_err is tied to 0.
// TESTING
//  1. Reset: rst_n=0 for 3 cycles with all req_valid=1 -> every output stays 0 and no
//     ack occurs. First grant after release goes to requester 0.
//  2. Single request: req_valid=4'b0100, data=32'h40800000 (4.0) -> req_ack=4'b0100 and
//     core_start at T+1. resp_valid=4'b0100 with resp_data=32'h3F000000 (0.5), err=0.
//  3. Round-robin: all four request continuously for 8 ops -> grant order
//     0,1,2,3,0,1,2,3 with exactly one ack per op.
//  4. Stale ready: hold core_ready=1 from the previous op across the new start ->
//     no response until ready falls and rises again.
//  5. Mid-op reset: assert rst_n=0 during WAIT, then release -> no resp_valid, rr_ptr=0.
//     A pending req_valid=4'b1000 is granted next.
//  6. (TIMEOUT_EN) Core never raises ready -> after 64 WAIT cycles: resp_valid[grant]=1,
//     resp_data=32'h7FC00000, resp_err=1. The next request is accepted normally.

Source files
------------

// File: rtl/invsqrt_arbiter.sv
// Round-robin arbiter sharing one invsqrt core among N_REQ requesters.
// Optional WAIT watchdog enabled by defining INVSQRT_ARB_TIMEOUT_EN.
module invsqrt_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned GW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    req_ack,
    output logic [N_REQ-1:0]    resp_valid,
    output logic [31:0]         resp_data,
    output logic                resp_err,
    output logic                busy,
    output logic                core_start,
    output logic [31:0]         core_float_in,
    input  logic [31:0]         core_float_out,
    input  logic                core_ready
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("invsqrt_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic              ready_q;
    logic [N_REQ-1:0]  req_ack_q, req_ack_d;
    logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              core_start_q, core_start_d;
    logic [31:0]       core_float_in_q, core_float_in_d;
    logic              busy_q;

    logic              hi_found, lo_found;
    logic [GW-1:0]     hi_idx, lo_idx, pick;
    logic [31:0]       pick_data;
    logic              complete;

    // Round-robin: prefer the first request at or above rr_ptr, else wrap to the lowest.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = GW'(i);
            end
            if (req_valid[i] && !hi_found && i >= int'(rr_ptr_q)) begin
                hi_found = 1'b1;
                hi_idx   = GW'(i);
            end
        end
        pick = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (GW'(i) == pick) pick_data = req_data[32*i +: 32];
        end
    end

    // A ready level carried over from the previous op is not a completion.
    assign complete = core_ready & ~ready_q;

`ifdef INVSQRT_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          resp_err_q, resp_err_d;
`endif

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        req_ack_d       = '0;
        resp_valid_d    = '0;
        resp_data_d     = resp_data_q;
        core_start_d    = 1'b0;
        core_float_in_d = core_float_in_q;
`ifdef INVSQRT_ARB_TIMEOUT_EN
        cnt_d           = cnt_q;
        resp_err_d      = resp_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    core_float_in_d = pick_data;
                    req_ack_d       = N_REQ'(1) << pick;
                    core_start_d    = 1'b1;
                    grant_d         = pick;
                    rr_ptr_d        = (pick == GW'(N_REQ - 1)) ? '0 : pick + GW'(1);
                    state_d         = StWait;
`ifdef INVSQRT_ARB_TIMEOUT_EN
                    cnt_d           = '0;
`endif
                end
            end
            StWait: begin
`ifdef INVSQRT_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CW'(1);
`endif
                if (complete) begin
                    resp_data_d  = core_float_out;
                    resp_valid_d = N_REQ'(1) << grant_q;
                    state_d      = StIdle;
`ifdef INVSQRT_ARB_TIMEOUT_EN
                    resp_err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_d  = 32'h7FC0_0000;
                    resp_valid_d = N_REQ'(1) << grant_q;
                    resp_err_d   = 1'b1;
                    state_d      = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            rr_ptr_q        <= '0;
            grant_q         <= '0;
            ready_q         <= 1'b0;
            req_ack_q       <= '0;
            resp_valid_q    <= '0;
            resp_data_q     <= '0;
            core_start_q    <= 1'b0;
            core_float_in_q <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_q         <= grant_d;
            ready_q         <= core_ready;
            req_ack_q       <= req_ack_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            core_start_q    <= core_start_d;
            core_float_in_q <= core_float_in_d;
            busy_q          <= (state_d == StWait);
        end
    end

`ifdef INVSQRT_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            resp_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            resp_err_q <= resp_err_d;
        end
    end
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ack       = req_ack_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign busy          = busy_q;
    assign core_start    = core_start_q;
    assign core_float_in = core_float_in_q;

endmodule
